// File: rtl/rename_pkg.sv
// Shared definitions for the rename stage.
// Holds the lane count, register index widths, the per-lane rename result
// record, and small helpers that slice one lane out of a flat lane bus.
package rename_pkg;

    localparam int LANES     = 4;
    localparam int AREG_W    = 5;
    localparam int PIDX_W    = 6;
    localparam int NUM_AREGS = 32;

    localparam logic [AREG_W-1:0] AREG_ZERO = {AREG_W{1'b0}};
    localparam logic [PIDX_W-1:0] PIDX_ZERO = {PIDX_W{1'b0}};

    // One renamed lane as handed to dispatch.
    typedef struct packed {
        logic              vld;
        logic              wen;
        logic [PIDX_W-1:0] prs1;
        logic [PIDX_W-1:0] prs2;
        logic [PIDX_W-1:0] prd;
        logic [PIDX_W-1:0] old_prd;
    } lane_res_t;

    localparam lane_res_t LANE_RES_ZERO = {$bits(lane_res_t){1'b0}};

    // Architectural index of lane k from a flat LANES*AREG_W bus.
    function automatic logic [AREG_W-1:0] lane_areg(input logic [LANES*AREG_W-1:0] bus,
                                                    input int k);
        return bus[k*AREG_W +: AREG_W];
    endfunction

    // Physical index of lane k from a flat LANES*PIDX_W bus.
    function automatic logic [PIDX_W-1:0] lane_pidx(input logic [LANES*PIDX_W-1:0] bus,
                                                    input int k);
        return bus[k*PIDX_W +: PIDX_W];
    endfunction

endpackage

// File: rtl/rename_map_if.sv
// Bundle of all rename-stage traffic except clock and reset:
// rename group in, freelist request/response, dispatch output,
// commit ports, flush and the sticky allocation error.
// slave  = the rename stage itself, master = its environment.
interface rename_map_if;
    import rename_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [LANES-1:0]         in_lane_vld;
    logic [LANES-1:0]         in_wen;
    logic [LANES*AREG_W-1:0]  in_rd;
    logic [LANES*AREG_W-1:0]  in_rs1;
    logic [LANES*AREG_W-1:0]  in_rs2;

    logic [LANES-1:0]         fl_req;
    logic [LANES*PIDX_W-1:0]  fl_pidx;
    logic [LANES-1:0]         fl_pvld;
    logic                     fl_busy;

    logic                     out_valid;
    logic                     out_ready;
    logic [LANES-1:0]         out_lane_vld;
    logic [LANES-1:0]         out_wen;
    logic [LANES*PIDX_W-1:0]  out_prs1;
    logic [LANES*PIDX_W-1:0]  out_prs2;
    logic [LANES*PIDX_W-1:0]  out_prd;
    logic [LANES*PIDX_W-1:0]  out_old_prd;

    logic [LANES-1:0]         cmt_valid;
    logic [LANES*AREG_W-1:0]  cmt_rd;
    logic [LANES*PIDX_W-1:0]  cmt_prd;

    logic                     flush;
    logic                     alloc_err;

    modport slave (
        input  in_valid, in_lane_vld, in_wen, in_rd, in_rs1, in_rs2,
        input  fl_pidx, fl_pvld, fl_busy,
        input  out_ready,
        input  cmt_valid, cmt_rd, cmt_prd,
        input  flush,
        output in_ready, fl_req,
        output out_valid, out_lane_vld, out_wen, out_prs1, out_prs2, out_prd, out_old_prd,
        output alloc_err
    );

    modport master (
        output in_valid, in_lane_vld, in_wen, in_rd, in_rs1, in_rs2,
        output fl_pidx, fl_pvld, fl_busy,
        output out_ready,
        output cmt_valid, cmt_rd, cmt_prd,
        output flush,
        input  in_ready, fl_req,
        input  out_valid, out_lane_vld, out_wen, out_prs1, out_prs2, out_prd, out_old_prd,
        input  alloc_err
    );

endinterface

// File: rtl/rename_bypass.sv
// Intra-group dependency resolution for one rename group.
// For each lane, sources and the previous destination mapping come from the
// youngest older lane in the same group that writes the same register,
// otherwise from the speculative map (values looked up by the caller).
// Ports: lane_vld/need per lane, rd/rs1/rs2 arch indices, prd per lane,
//        smt_rs1/smt_rs2/smt_rd map lookups; outputs prs1/prs2/old_prd.
module rename_bypass
    import rename_pkg::*;
(
    input  logic [LANES-1:0]  lane_vld,
    input  logic [LANES-1:0]  need,
    input  logic [AREG_W-1:0] rd      [LANES],
    input  logic [AREG_W-1:0] rs1     [LANES],
    input  logic [AREG_W-1:0] rs2     [LANES],
    input  logic [PIDX_W-1:0] prd     [LANES],
    input  logic [PIDX_W-1:0] smt_rs1 [LANES],
    input  logic [PIDX_W-1:0] smt_rs2 [LANES],
    input  logic [PIDX_W-1:0] smt_rd  [LANES],
    output logic [PIDX_W-1:0] prs1    [LANES],
    output logic [PIDX_W-1:0] prs2    [LANES],
    output logic [PIDX_W-1:0] old_prd [LANES]
);

    // Priority match: scanning older lanes in ascending order lets the youngest match win.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            prs1[k]    = (rs1[k] == AREG_ZERO) ? PIDX_ZERO : smt_rs1[k];
            prs2[k]    = (rs2[k] == AREG_ZERO) ? PIDX_ZERO : smt_rs2[k];
            old_prd[k] = smt_rd[k];
            for (int j = 0; j < LANES; j++) begin
                // need[j] already excludes x0, so a hit never aliases the zero register.
                prs1[k]    = ((j < k) && need[j] && (rd[j] == rs1[k])) ? prd[j] : prs1[k];
                prs2[k]    = ((j < k) && need[j] && (rd[j] == rs2[k])) ? prd[j] : prs2[k];
                old_prd[k] = ((j < k) && need[j] && (rd[j] == rd[k]))  ? prd[j] : old_prd[k];
            end
            prs1[k]    = lane_vld[k] ? prs1[k] : PIDX_ZERO;
            prs2[k]    = lane_vld[k] ? prs2[k] : PIDX_ZERO;
            old_prd[k] = need[k]     ? old_prd[k] : PIDX_ZERO;
        end
    end

endmodule

// File: rtl/rename_map.sv
// 4-wide register rename stage sitting behind the freelist.
// Allocates a physical register per written destination, looks sources up in
// the speculative map (SMT), resolves same-group dependencies, and registers
// the result for dispatch. A committed map (CMT) is kept from commit ports and
// copied into the SMT on flush.
// Ports: clock, reset (synchronous, active-low), rn = rename_map_if.slave.
module rename_map
    import rename_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    rename_map_if.slave  rn
);

    logic [PIDX_W-1:0] smt_r      [NUM_AREGS];
    logic [PIDX_W-1:0] cmt_r      [NUM_AREGS];
    logic [PIDX_W-1:0] smt_next_s [NUM_AREGS];
    logic [PIDX_W-1:0] cmt_next_s [NUM_AREGS];

    logic [LANES-1:0]  need_s;
    logic [AREG_W-1:0] rd_s      [LANES];
    logic [AREG_W-1:0] rs1_s     [LANES];
    logic [AREG_W-1:0] rs2_s     [LANES];
    logic [PIDX_W-1:0] prd_s     [LANES];
    logic [PIDX_W-1:0] smt_rs1_s [LANES];
    logic [PIDX_W-1:0] smt_rs2_s [LANES];
    logic [PIDX_W-1:0] smt_rd_s  [LANES];
    logic [PIDX_W-1:0] prs1_s    [LANES];
    logic [PIDX_W-1:0] prs2_s    [LANES];
    logic [PIDX_W-1:0] old_prd_s [LANES];
    lane_res_t         lane_res_s [LANES];

    logic              in_ready_s;
    logic              accept_s;
    logic              alloc_fail_s;

    logic              out_valid_r;
    lane_res_t         out_lane_r [LANES];
    logic              alloc_err_r;

    // Per-lane decode, freelist index selection and SMT lookups (pre-update values).
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            rd_s[k]      = lane_areg(rn.in_rd, k);
            rs1_s[k]     = lane_areg(rn.in_rs1, k);
            rs2_s[k]     = lane_areg(rn.in_rs2, k);
            need_s[k]    = rn.in_lane_vld[k] & rn.in_wen[k] & (rd_s[k] != AREG_ZERO);
            prd_s[k]     = need_s[k] ? lane_pidx(rn.fl_pidx, k) : PIDX_ZERO;
            smt_rs1_s[k] = smt_r[rs1_s[k]];
            smt_rs2_s[k] = smt_r[rs2_s[k]];
            smt_rd_s[k]  = smt_r[rd_s[k]];
        end
    end

    // Handshake: flush and a short freelist both stall the group; the freelist
    // commits the allocation at the same edge, so fl_req only fires on accept.
    always_comb begin
        in_ready_s   = reset & ~rn.flush & ~rn.fl_busy & (~out_valid_r | rn.out_ready);
        accept_s     = rn.in_valid & in_ready_s;
        rn.in_ready  = in_ready_s;
        rn.fl_req    = accept_s ? need_s : {LANES{1'b0}};
        alloc_fail_s = accept_s & (|(need_s & ~rn.fl_pvld));
    end

    rename_bypass u_bypass (
        .lane_vld (rn.in_lane_vld),
        .need     (need_s),
        .rd       (rd_s),
        .rs1      (rs1_s),
        .rs2      (rs2_s),
        .prd      (prd_s),
        .smt_rs1  (smt_rs1_s),
        .smt_rs2  (smt_rs2_s),
        .smt_rd   (smt_rd_s),
        .prs1     (prs1_s),
        .prs2     (prs2_s),
        .old_prd  (old_prd_s)
    );

    // Assemble the lane results to be captured by the output register.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_res_s[k].vld     = rn.in_lane_vld[k];
            lane_res_s[k].wen     = rn.in_lane_vld[k] & rn.in_wen[k];
            lane_res_s[k].prs1    = prs1_s[k];
            lane_res_s[k].prs2    = prs2_s[k];
            lane_res_s[k].prd     = prd_s[k];
            lane_res_s[k].old_prd = old_prd_s[k];
        end
    end

    // Next map values; ascending lane scan makes the highest/youngest lane win.
    always_comb begin
        for (int i = 0; i < NUM_AREGS; i++) begin
            cmt_next_s[i] = cmt_r[i];
            smt_next_s[i] = smt_r[i];
            for (int k = 0; k < LANES; k++) begin
                cmt_next_s[i] = (rn.cmt_valid[k] && (i != 0) &&
                                 (lane_areg(rn.cmt_rd, k) == AREG_W'(i)))
                                ? lane_pidx(rn.cmt_prd, k) : cmt_next_s[i];
                smt_next_s[i] = (accept_s && need_s[k] && (rd_s[k] == AREG_W'(i)))
                                ? prd_s[k] : smt_next_s[i];
            end
        end
    end

    // Map tables: identity on reset; flush copies the CMT including this edge's commits.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_AREGS; i++) begin
                smt_r[i] <= PIDX_W'(i);
                cmt_r[i] <= PIDX_W'(i);
            end
        end else begin
            for (int i = 0; i < NUM_AREGS; i++) begin
                cmt_r[i] <= cmt_next_s[i];
                smt_r[i] <= rn.flush ? cmt_next_s[i] : smt_next_s[i];
            end
        end
    end

    // Output register: loads on accept, holds under backpressure, dropped by flush.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                out_lane_r[k] <= LANE_RES_ZERO;
            end
        end else if (rn.flush) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            for (int k = 0; k < LANES; k++) begin
                out_lane_r[k] <= lane_res_s[k];
            end
        end else if (rn.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Sticky allocation error: cleared only by reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            alloc_err_r <= 1'b0;
        end else begin
            alloc_err_r <= alloc_err_r | alloc_fail_s;
        end
    end

    // Flatten the output register onto the dispatch buses.
    always_comb begin
        rn.out_valid    = out_valid_r;
        rn.alloc_err    = alloc_err_r;
        rn.out_lane_vld = {LANES{1'b0}};
        rn.out_wen      = {LANES{1'b0}};
        rn.out_prs1     = {(LANES*PIDX_W){1'b0}};
        rn.out_prs2     = {(LANES*PIDX_W){1'b0}};
        rn.out_prd      = {(LANES*PIDX_W){1'b0}};
        rn.out_old_prd  = {(LANES*PIDX_W){1'b0}};
        for (int k = 0; k < LANES; k++) begin
            rn.out_lane_vld[k]                  = out_lane_r[k].vld;
            rn.out_wen[k]                       = out_lane_r[k].wen;
            rn.out_prs1[k*PIDX_W +: PIDX_W]     = out_lane_r[k].prs1;
            rn.out_prs2[k*PIDX_W +: PIDX_W]     = out_lane_r[k].prs2;
            rn.out_prd[k*PIDX_W +: PIDX_W]      = out_lane_r[k].prd;
            rn.out_old_prd[k*PIDX_W +: PIDX_W]  = out_lane_r[k].old_prd;
        end
    end

endmodule

// File: tb/tb_rename_map.sv
// Self-checking bench for rename_map. A reference model renames each accepted
// group lane by lane against a working copy of the map, pushes the expected
// dispatch group to a queue, and the queue head is compared whenever the DUT
// presents out_valid.
module tb_rename_map;
    import rename_pkg::*;

    typedef struct packed {
        logic [LANES-1:0]        lv;
        logic [LANES-1:0]        wen;
        logic [LANES*PIDX_W-1:0] prs1;
        logic [LANES*PIDX_W-1:0] prs2;
        logic [LANES*PIDX_W-1:0] prd;
        logic [LANES*PIDX_W-1:0] old_prd;
    } grp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    rename_map_if bus ();

    rename_map dut (
        .clock (clock),
        .reset (reset),
        .rn    (bus)
    );

    always #5 clock = ~clock;

    int   n_cmp = 0;
    int   n_bad = 0;
    grp_t sb_q[$];
    logic [PIDX_W-1:0] m_smt [NUM_AREGS];
    logic [PIDX_W-1:0] m_cmt [NUM_AREGS];
    logic m_out_valid = 1'b0;
    logic m_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_AREGS; i++) begin
            m_smt[i] = PIDX_W'(i);
            m_cmt[i] = PIDX_W'(i);
        end
        sb_q.delete();
        m_out_valid = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic idle();
        bus.in_valid    = 1'b0;
        bus.in_lane_vld = '0;
        bus.in_wen      = '0;
        bus.in_rd       = '0;
        bus.in_rs1      = '0;
        bus.in_rs2      = '0;
        bus.fl_pidx     = '0;
        bus.fl_pvld     = '1;
        bus.fl_busy     = 1'b0;
        bus.out_ready   = 1'b1;
        bus.cmt_valid   = '0;
        bus.cmt_rd      = '0;
        bus.cmt_prd     = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic lane(input int k, input logic wen, input logic [AREG_W-1:0] rd,
                        input logic [AREG_W-1:0] rs1, input logic [AREG_W-1:0] rs2,
                        input logic [PIDX_W-1:0] pidx);
        bus.in_lane_vld[k]               = 1'b1;
        bus.in_wen[k]                    = wen;
        bus.in_rd[k*AREG_W +: AREG_W]    = rd;
        bus.in_rs1[k*AREG_W +: AREG_W]   = rs1;
        bus.in_rs2[k*AREG_W +: AREG_W]   = rs2;
        bus.fl_pidx[k*PIDX_W +: PIDX_W]  = pidx;
    endtask

    // One clock: entered just after a falling edge with inputs driven, leaves at the next falling edge.
    task automatic tick();
        logic [LANES-1:0]  need;
        logic [LANES-1:0]  exp_req;
        logic              exp_ready;
        logic              acc;
        logic              rst_edge;
        logic [AREG_W-1:0] rd, rs1, rs2, crd;
        logic [PIDX_W-1:0] pidx;
        logic [PIDX_W-1:0] tmp [NUM_AREGS];
        grp_t              g;

        #1;
        for (int k = 0; k < LANES; k++) begin
            need[k] = bus.in_lane_vld[k] && bus.in_wen[k] &&
                      (bus.in_rd[k*AREG_W +: AREG_W] != AREG_W'(0));
        end
        exp_ready = reset && !bus.flush && !bus.fl_busy && (!m_out_valid || bus.out_ready);
        acc       = bus.in_valid && exp_ready;
        exp_req   = acc ? need : '0;
        check("in_ready", bus.in_ready, exp_ready);
        check("fl_req", bus.fl_req, exp_req);
        check("out_valid", bus.out_valid, m_out_valid);

        if (m_out_valid) begin
            check("sb_nonempty", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
                g = sb_q[0];
                check("out_lane_vld", bus.out_lane_vld, g.lv);
                check("out_wen", bus.out_wen, g.wen);
                check("out_prs1", bus.out_prs1, g.prs1);
                check("out_prs2", bus.out_prs2, g.prs2);
                check("out_prd", bus.out_prd, g.prd);
                check("out_old_prd", bus.out_old_prd, g.old_prd);
                if (reset && (bus.out_ready || bus.flush)) begin
                    g = sb_q.pop_front();
                end
            end
        end

        rst_edge = !reset;
        if (!reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < NUM_AREGS; i++) tmp[i] = m_smt[i];
            if (acc) begin
                g = '0;
                for (int k = 0; k < LANES; k++) begin
                    if (bus.in_lane_vld[k]) begin
                        rd   = bus.in_rd[k*AREG_W +: AREG_W];
                        rs1  = bus.in_rs1[k*AREG_W +: AREG_W];
                        rs2  = bus.in_rs2[k*AREG_W +: AREG_W];
                        pidx = bus.fl_pidx[k*PIDX_W +: PIDX_W];
                        g.lv[k]  = 1'b1;
                        g.wen[k] = bus.in_wen[k];
                        g.prs1[k*PIDX_W +: PIDX_W] = (rs1 == AREG_W'(0)) ? PIDX_W'(0) : tmp[rs1];
                        g.prs2[k*PIDX_W +: PIDX_W] = (rs2 == AREG_W'(0)) ? PIDX_W'(0) : tmp[rs2];
                        if (need[k]) begin
                            g.old_prd[k*PIDX_W +: PIDX_W] = tmp[rd];
                            g.prd[k*PIDX_W +: PIDX_W]     = pidx;
                            tmp[rd] = pidx;
                            if (!bus.fl_pvld[k]) m_err = 1'b1;
                        end
                    end
                end
                sb_q.push_back(g);
            end
            for (int k = 0; k < LANES; k++) begin
                crd = bus.cmt_rd[k*AREG_W +: AREG_W];
                if (bus.cmt_valid[k] && crd != AREG_W'(0)) m_cmt[crd] = bus.cmt_prd[k*PIDX_W +: PIDX_W];
            end
            for (int i = 0; i < NUM_AREGS; i++) begin
                if (bus.flush) m_smt[i] = m_cmt[i];
                else if (acc) m_smt[i] = tmp[i];
            end
            if (acc) m_out_valid = 1'b1;
            else if (bus.flush || bus.out_ready) m_out_valid = 1'b0;
        end

        @(posedge clock);
        #1;
        check("alloc_err", bus.alloc_err, m_err);
        check("out_valid_post", bus.out_valid, m_out_valid);
        if (rst_edge) begin
            check("rst_out_prd", bus.out_prd, 0);
            check("rst_out_old_prd", bus.out_old_prd, 0);
            check("rst_out_prs1", bus.out_prs1, 0);
        end
        @(negedge clock);
    endtask

    initial begin
        idle();
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        model_reset();

        // Held in reset with a group offered: nothing accepted, no requests.
        lane(0, 1'b1, 5'd5, 5'd1, 5'd2, 6'd50);
        bus.in_valid = 1'b1;
        tick();
        tick();
        reset = 1'b1;

        // First rename of x5, then a read of x5 sees the new mapping.
        idle();
        lane(0, 1'b1, 5'd5, 5'd5, 5'd0, 6'd32);
        bus.in_valid = 1'b1;
        #1 check("t1_fl_req", bus.fl_req, 4'b0001);
        tick();
        check("t1_prs1", bus.out_prs1[5:0], 6'd5);
        check("t1_prs2", bus.out_prs2[5:0], 6'd0);
        check("t1_prd", bus.out_prd[5:0], 6'd32);
        check("t1_old_prd", bus.out_old_prd[5:0], 6'd5);
        idle();
        lane(0, 1'b0, 5'd0, 5'd5, 5'd0, 6'd0);
        bus.in_valid = 1'b1;
        tick();
        check("t1_fwd", bus.out_prs1[5:0], 6'd32);

        // Same-group chain on x3.
        idle();
        lane(0, 1'b1, 5'd3, 5'd0, 5'd0, 6'd32);
        lane(1, 1'b1, 5'd3, 5'd3, 5'd0, 6'd33);
        lane(2, 1'b0, 5'd0, 5'd0, 5'd3, 6'd0);
        bus.in_valid = 1'b1;
        tick();
        check("t2_l1_prs1", bus.out_prs1[11:6], 6'd32);
        check("t2_l1_old", bus.out_old_prd[11:6], 6'd32);
        check("t2_l2_prs2", bus.out_prs2[17:12], 6'd33);
        idle();
        lane(0, 1'b0, 5'd0, 5'd3, 5'd0, 6'd0);
        bus.in_valid = 1'b1;
        tick();
        check("t2_smt3", bus.out_prs1[5:0], 6'd33);

        // Freelist busy stalls the group.
        idle();
        lane(0, 1'b1, 5'd9, 5'd1, 5'd2, 6'd34);
        bus.in_valid = 1'b1;
        bus.fl_busy  = 1'b1;
        tick();
        tick();
        bus.fl_busy = 1'b0;
        tick();
        check("t3_prd", bus.out_prd[5:0], 6'd34);

        // Dispatch backpressure holds the output and blocks input.
        idle();
        lane(0, 1'b1, 5'd10, 5'd0, 5'd0, 6'd35);
        bus.in_valid = 1'b1;
        tick();
        idle();
        lane(0, 1'b1, 5'd11, 5'd10, 5'd0, 6'd36);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t4_hold_prd", bus.out_prd[5:0], 6'd35);
        end
        bus.out_ready = 1'b1;
        tick();
        check("t4_new_prd", bus.out_prd[5:0], 6'd36);
        check("t4_new_prs1", bus.out_prs1[5:0], 6'd35);

        // Flush without commit restores identity for x7.
        idle();
        lane(0, 1'b1, 5'd7, 5'd0, 5'd0, 6'd40);
        bus.in_valid = 1'b1;
        tick();
        idle();
        lane(0, 1'b0, 5'd0, 5'd7, 5'd0, 6'd0);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        tick();
        idle();
        lane(0, 1'b0, 5'd0, 5'd7, 5'd0, 6'd0);
        bus.in_valid = 1'b1;
        tick();
        check("t5_flush_id", bus.out_prs1[5:0], 6'd7);

        // Flush with a same-cycle commit of x7 -> 40.
        idle();
        lane(0, 1'b1, 5'd7, 5'd0, 5'd0, 6'd40);
        bus.in_valid = 1'b1;
        tick();
        idle();
        bus.flush        = 1'b1;
        bus.cmt_valid[0] = 1'b1;
        bus.cmt_rd[4:0]  = 5'd7;
        bus.cmt_prd[5:0] = 6'd40;
        tick();
        idle();
        lane(0, 1'b0, 5'd0, 5'd7, 5'd0, 6'd0);
        bus.in_valid = 1'b1;
        tick();
        check("t5_flush_cmt", bus.out_prs1[5:0], 6'd40);

        // x0 destination allocates nothing.
        idle();
        lane(0, 1'b1, 5'd0, 5'd4, 5'd0, 6'd41);
        bus.in_valid = 1'b1;
        #1 check("t6_x0_req", bus.fl_req, 4'b0000);
        tick();
        check("t6_x0_prd", bus.out_prd[5:0], 6'd0);
        check("t6_x0_old", bus.out_old_prd[5:0], 6'd0);

        // Missing freelist entry sets the sticky error; reset clears it.
        idle();
        lane(1, 1'b1, 5'd12, 5'd0, 5'd0, 6'd42);
        bus.fl_pvld  = 4'b1101;
        bus.in_valid = 1'b1;
        tick();
        check("t6_err_set", bus.alloc_err, 1'b1);
        idle();
        tick();
        tick();
        check("t6_err_sticky", bus.alloc_err, 1'b1);
        reset = 1'b0;
        tick();
        check("t6_err_clr", bus.alloc_err, 1'b0);
        reset = 1'b1;
        idle();
        lane(0, 1'b0, 5'd0, 5'd7, 5'd0, 6'd0);
        bus.in_valid = 1'b1;
        tick();
        check("t6_rst_id", bus.out_prs1[5:0], 6'd7);

        // Random traffic with collisions, commits, flushes and stalls.
        for (int c = 0; c < 80; c++) begin
            idle();
            bus.in_valid = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < LANES; k++) begin
                if ($urandom_range(0, 3) != 0) begin
                    lane(k, 1'($urandom_range(0, 1)), AREG_W'($urandom_range(0, 7)),
                         AREG_W'($urandom_range(0, 7)), AREG_W'($urandom_range(0, 7)),
                         PIDX_W'($urandom_range(0, 63)));
                end
                bus.cmt_valid[k]                 = 1'($urandom_range(0, 1));
                bus.cmt_rd[k*AREG_W +: AREG_W]   = AREG_W'($urandom_range(0, 7));
                bus.cmt_prd[k*PIDX_W +: PIDX_W]  = PIDX_W'($urandom_range(0, 63));
            end
            bus.fl_busy   = ($urandom_range(0, 7) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 15) == 0);
            tick();
        end

        idle();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
